// File: rtl/eng_uc_port_if.sv
// Unit-clause arbiter endpoint bus.
// Groups the core-side push path, the outbox head presented to the arbiter,
// the arbiter select/read strobe, and the broadcast returned to the core.
// slave  : view of the per-engine endpoint (eng_uc_port)
// master : view of the core + arbiter driving the endpoint
interface eng_uc_port_if #(
  parameter int unsigned UC_LENGTH  = 64,
  parameter int unsigned NUM_ENGINE = 4
);
  localparam int unsigned LW = $clog2(UC_LENGTH);

  logic                  core_push;
  logic signed [LW-1:0]  core_lit;
  logic                  core_full;
  logic signed [LW-1:0]  eng2uca;
  logic                  eng2uca_valid;
  logic                  eng2uca_empty;
  logic [NUM_ENGINE-1:0] engmask;
  logic                  eng2uca_rd;
  logic signed [LW-1:0]  uca2eng;
  logic                  uca2eng_valid;
  logic                  conflict;
  logic signed [LW-1:0]  bcast_lit;
  logic                  bcast_valid;
  logic                  local_conflict;

  modport slave (
    input  core_push, core_lit, engmask, eng2uca_rd, uca2eng, uca2eng_valid, conflict,
    output core_full, eng2uca, eng2uca_valid, eng2uca_empty,
           bcast_lit, bcast_valid, local_conflict
  );

  modport master (
    output core_push, core_lit, engmask, eng2uca_rd, uca2eng, uca2eng_valid, conflict,
    input  core_full, eng2uca, eng2uca_valid, eng2uca_empty,
           bcast_lit, bcast_valid, local_conflict
  );
endinterface

// File: rtl/eng_uc_port.sv
// Per-engine endpoint of the unit-clause arbiter.
// Buffers unit literals from the BCP core in an outbox FIFO, presents the head
// to the arbiter and pops on a selected read strobe. Registers the arbiter
// broadcast for the core; drops core literals that duplicate the broadcast and
// pulses local_conflict for literals that contradict it.
// Ports: clk, rst (sync, active-low), bus (eng_uc_port_if.slave).
module eng_uc_port #(
  parameter int unsigned UC_LENGTH  = 64,
  parameter int unsigned NUM_ENGINE = 4,
  parameter int unsigned ENG_ID     = 0,
  parameter int unsigned DEPTH      = 8
) (
  input  logic          clk,
  input  logic          rst,
  eng_uc_port_if.slave  bus
);
  localparam int unsigned LW = $clog2(UC_LENGTH);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

  logic signed [LW-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic signed [LW-1:0] bcast_lit_q;
  logic                 bcast_valid_q;
  logic                 local_conflict_q;

  logic                 sel;
  logic                 full;
  logic                 pop;
  logic                 cand;
  logic                 dup;
  logic                 contra;
  logic                 push;
  logic signed [LW-1:0] neg_bcast;

  // Push/pop qualification; conflict suppresses both.
  always_comb begin
    sel       = bus.engmask[SW'(ENG_ID)];
    full      = (count == CW'(DEPTH));
    neg_bcast = -bus.uca2eng;
    pop       = bus.eng2uca_rd && sel && (count != '0) && !bus.conflict;
    cand      = bus.core_push && (bus.core_lit != '0);
    dup       = bus.uca2eng_valid && (bus.core_lit == bus.uca2eng);
    contra    = bus.uca2eng_valid && (bus.core_lit == neg_bcast);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push      = cand && !dup && !contra && (!full || pop) && !bus.conflict;
  end

  // Outbox storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.core_lit;
  end

  // Pointers, occupancy and the registered broadcast path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      bcast_lit_q      <= '0;
      bcast_valid_q    <= 1'b0;
      local_conflict_q <= 1'b0;
    end else begin
      if (bus.conflict) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      bcast_valid_q    <= bus.uca2eng_valid;
      bcast_lit_q      <= bus.uca2eng_valid ? bus.uca2eng : '0;
      local_conflict_q <= cand && contra;
    end
  end

  // Head and status decode from registered state only (no fall-through).
  assign bus.eng2uca        = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.eng2uca_valid  = (count != '0);
  assign bus.eng2uca_empty  = (count == '0);
  assign bus.core_full      = full;
  assign bus.bcast_lit      = bcast_lit_q;
  assign bus.bcast_valid    = bcast_valid_q;
  assign bus.local_conflict = local_conflict_q;
endmodule
